// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the load/store unit data port. One access is
// accepted at a time. Each access runs IDLE -> (WAIT) -> ACCESS -> RESP.
// Store data arrives low-aligned and is moved onto the addressed byte lanes
// of a word-organised synchronous RAM. Load data is returned shifted down,
// so the addressed byte or halfword lands in bits [7:0] / [15:0].
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the RAM (power of two)
//   BASE_ADDR    byte address of word 0
//   WAIT_STATES  extra cycles before the RAM access (0..15)
//
// Ports
//   clk            clock; all state changes on the rising edge
//   rst            synchronous active-high reset
//   mem_read_req   read request, held by the requester until ack
//   mem_write_req  low-aligned byte enables (0001 SB, 0011 SH, 1111 SW)
//   addr           byte address of the access
//   store_data     low-aligned write data
//   load_data      low-aligned read data, valid with ack
//   ack            one-cycle completion pulse
//   bus_error      valid with ack; the access was rejected
//   busy           set on capture, cleared when the response is issued
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_req,
   input  logic [3:0]  mem_write_req,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        ack,
   output logic        bus_error,
   output logic        busy
);

   localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------

   // Byte enables moved to their lanes; bits [6:4] catch enables pushed past
   // the top of the word by a misaligned address.
   function automatic logic [6:0] widen_strobe(input logic [3:0] be, input logic [1:0] off);
      widen_strobe = {3'b000, be} << off;
   endfunction

   // Only byte, halfword and word stores are legal enable patterns.
   function automatic logic legal_be(input logic [3:0] be);
      case (be)
         4'b0001: legal_be = 1'b1;
         4'b0011: legal_be = 1'b1;
         4'b1111: legal_be = 1'b1;
         default: legal_be = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] lanes_up(input logic [31:0] data, input logic [1:0] off);
      lanes_up = data << {off, 3'b000};
   endfunction

   function automatic logic [31:0] lanes_down(input logic [31:0] data, input logic [1:0] off);
      lanes_down = data >> {off, 3'b000};
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t      state_r;
   logic [31:0] addr_r;
   logic [31:0] data_r;
   logic [3:0]  be_r;
   logic        is_wr_r;
   logic [3:0]  wait_cnt_r;
   logic [31:0] rd_word_r;

   logic [31:0] mem_r [DEPTH_WORDS];

   // ---------------------------------------------------------------------------
   // Decode of the captured access
   // ---------------------------------------------------------------------------
   logic          req_s;
   logic [1:0]    off_s;
   logic [31:0]   rel_s;
   logic [31:0]   word_idx_s;
   logic          range_err_s;
   logic [6:0]    strb_wide_s;
   logic [3:0]    lane_strb_s;
   logic [31:0]   lane_data_s;
   logic          shift_err_s;
   logic          be_err_s;
   logic          access_err_s;
   logic [AW-1:0] ram_idx_s;
   logic          ram_we_s;

   // Request detect and address / lane / error decode of the held access.
   always_comb begin
      req_s       = mem_read_req | (|mem_write_req);
      off_s       = addr_r[1:0];
      rel_s       = addr_r - BASE_ADDR;
      word_idx_s  = rel_s >> 2;
      // An address below the base would wrap into range through the
      // subtraction, so it is rejected separately.
      range_err_s = (addr_r < BASE_ADDR) || (word_idx_s >= 32'(DEPTH_WORDS));
      strb_wide_s = widen_strobe(be_r, off_s);
      lane_strb_s = strb_wide_s[3:0];
      lane_data_s = lanes_up(data_r, off_s);
      if (is_wr_r) begin
         shift_err_s = |strb_wide_s[6:4];
         be_err_s    = ~legal_be(be_r);
      end else begin
         shift_err_s = 1'b0;
         be_err_s    = 1'b0;
      end
      access_err_s = range_err_s | shift_err_s | be_err_s;
      ram_idx_s    = word_idx_s[AW-1:0];
      // rst gates the write so a reset in the ACCESS cycle leaves RAM intact.
      ram_we_s     = (state_r == ST_ACCESS) && is_wr_r && !access_err_s && !rst;
   end

   // RAM write port: byte-lane writes; contents are never reset.
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_strb_s[i]) begin
               mem_r[ram_idx_s][8*i +: 8] <= lane_data_s[8*i +: 8];
            end
         end
      end
   end

   // Access sequencer: capture, wait states, RAM read, registered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         addr_r     <= 32'h0000_0000;
         data_r     <= 32'h0000_0000;
         be_r       <= 4'b0000;
         is_wr_r    <= 1'b0;
         wait_cnt_r <= 4'd0;
         rd_word_r  <= 32'h0000_0000;
         load_data  <= 32'h0000_0000;
         ack        <= 1'b0;
         bus_error  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         ack <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // During the ack cycle the requester still holds the finished
               // request; skipping capture then avoids serving it twice.
               if (req_s && !ack) begin
                  addr_r  <= addr;
                  data_r  <= store_data;
                  be_r    <= mem_write_req;
                  is_wr_r <= |mem_write_req;   // write wins over a read
                  busy    <= 1'b1;
                  if (WAIT_STATES > 0) begin
                     wait_cnt_r <= 4'd1;
                     state_r    <= ST_WAIT;
                  end else begin
                     wait_cnt_r <= 4'd0;
                     state_r    <= ST_ACCESS;
                  end
               end
            end
            ST_WAIT: begin
               // Counter stops at WAIT_STATES and never wraps.
               if (wait_cnt_r >= WAIT_CNT) begin
                  state_r <= ST_ACCESS;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 4'd1;
               end
            end
            ST_ACCESS: begin
               rd_word_r  <= mem_r[ram_idx_s];
               wait_cnt_r <= 4'd0;
               state_r    <= ST_RESP;
            end
            ST_RESP: begin
               ack       <= 1'b1;
               bus_error <= access_err_s;
               if (access_err_s || is_wr_r) begin
                  load_data <= 32'h0000_0000;
               end else begin
                  load_data <= lanes_down(rd_word_r, off_s);
               end
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
